// File: rtl/traffic_demand_scheduler_if.sv
// Signal bundle between an intersection controller and its scheduler.
// It carries the demand and preemption inputs and the registered head aspects and status.
interface traffic_demand_scheduler_if;
  logic [3:0] req;
  logic       emerg_valid;
  logic [1:0] emerg_dir;
  logic [1:0] r1, r2, r3, r4;
  logic [1:0] active_dir;
  logic [2:0] phase;

  modport master (output req, emerg_valid, emerg_dir,
                  input  r1, r2, r3, r4, active_dir, phase);
  modport slave  (input  req, emerg_valid, emerg_dir,
                  output r1, r2, r3, r4, active_dir, phase);
endinterface

// File: rtl/traffic_demand_scheduler.sv
// Demand-actuated 4-way phase scheduler with round-robin fairness and emergency preemption.
// Head aspects are registered from the next state, so they change in the same cycle as the phase.
module traffic_demand_scheduler #(
  parameter int MIN_GREEN    = 3,
  parameter int MAX_GREEN    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 2,
  parameter int TIMER_W      = 8
) (
  input logic clk,
  input logic rst,
  traffic_demand_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    PH_ALL_RED = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_EMERG   = 3'd3
  } phase_e;

  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] Y_T   = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_T  = TIMER_W'(ALL_RED_TIME - 1);

  phase_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         active_q, active_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0][1:0]    heads_q, heads_d;

  logic [3:0] other;
  logic [1:0] pick, idx;
  logic       found;
  logic       emerg_here;

  assign other      = bus.req & ~(4'b0001 << active_q);
  assign emerg_here = bus.emerg_valid && (bus.emerg_dir == active_q);

  // Round-robin: first requesting approach at or after ptr, wrapping mod 4.
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    case (state_q)
      PH_ALL_RED: begin
        if (timer_q != AR_T) begin
          timer_d = timer_q + T_ONE;
        end else if (bus.emerg_valid) begin
          state_d  = PH_EMERG;
          active_d = bus.emerg_dir;
          timer_d  = '0;
        end else if (bus.req != 4'b0000) begin
          state_d  = PH_GREEN;
          active_d = pick;
          ptr_d    = pick + 2'd1;
          timer_d  = '0;
        end
      end
      PH_GREEN: begin
        if (bus.emerg_valid && !emerg_here) begin
          state_d = PH_YELLOW;
          timer_d = '0;
        end else if (emerg_here) begin
          state_d = PH_EMERG;
          timer_d = '0;
        end else if (other != 4'b0000 &&
                     ((timer_q >= MIN_T && !bus.req[active_q]) || timer_q == MAX_T)) begin
          state_d = PH_YELLOW;
          timer_d = '0;
        end else if (timer_q != MAX_T) begin
          timer_d = timer_q + T_ONE;
        end
      end
      PH_YELLOW: begin
        if (timer_q == Y_T) begin
          state_d = PH_ALL_RED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      PH_EMERG: begin
        if (!emerg_here) begin
          state_d = PH_YELLOW;
          timer_d = '0;
        end
      end
      default: begin
        state_d = PH_ALL_RED;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    heads_d = '0;
    case (state_d)
      PH_GREEN, PH_EMERG: heads_d[active_d] = 2'b10;
      PH_YELLOW:          heads_d[active_d] = 2'b01;
      default:            heads_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PH_ALL_RED;
      timer_q  <= '0;
      active_q <= 2'd0;
      ptr_q    <= 2'd0;
      heads_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      heads_q  <= heads_d;
    end
  end

  assign bus.r1         = heads_q[0];
  assign bus.r2         = heads_q[1];
  assign bus.r3         = heads_q[2];
  assign bus.r4         = heads_q[3];
  assign bus.active_dir = active_q;
  assign bus.phase      = state_q;
endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// Directed segment-table bench for the demand scheduler with a continuous head-safety monitor.
module tb_traffic_demand_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  traffic_demand_scheduler_if ifc ();

  traffic_demand_scheduler #(
    .MIN_GREEN(3), .MAX_GREEN(8), .YELLOW_TIME(2), .ALL_RED_TIME(2), .TIMER_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // One record covers n consecutive cycles with constant inputs and expected outputs.
  // heads is {r4, r3, r2, r1}.
  typedef struct {
    bit         rst_first;
    int         n;
    logic [3:0] req;
    logic       ev;
    logic [1:0] ed;
    logic [7:0] heads;
    logic [2:0] ph;
    logic [1:0] ad;
  } seg_t;

  seg_t segs[$];

  function automatic seg_t S(bit r, int n, logic [3:0] req, logic ev, logic [1:0] ed,
                             logic [7:0] heads, logic [2:0] ph, logic [1:0] ad);
    seg_t s;
    s.rst_first = r; s.n = n; s.req = req; s.ev = ev; s.ed = ed;
    s.heads = heads; s.ph = ph; s.ad = ad;
    return s;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req = 4'b0000; ifc.emerg_valid = 1'b0; ifc.emerg_dir = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_seg(seg_t s);
    for (int c = 0; c < s.n; c++) begin
      ifc.req = s.req; ifc.emerg_valid = s.ev; ifc.emerg_dir = s.ed;
      @(negedge clk);
      chk("heads", {ifc.r4, ifc.r3, ifc.r2, ifc.r1}, s.heads);
      chk("phase", 8'(ifc.phase), 8'(s.ph));
      chk("active_dir", 8'(ifc.active_dir), 8'(s.ad));
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  // Safety monitor: one non-red head at most, no 11, no 10->00 or 00->01.
  logic [1:0] prev_h [4] = '{default: 2'b00};
  always @(negedge clk) begin
    logic [1:0] h [4];
    int nz;
    logic bad;
    h[0] = ifc.r1; h[1] = ifc.r2; h[2] = ifc.r3; h[3] = ifc.r4;
    if (rst) begin
      for (int i = 0; i < 4; i++) prev_h[i] = 2'b00;
    end else begin
      nz = 0; bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (h[i] != 2'b00) nz++;
        if (h[i] === 2'b11) bad = 1'b1;
        if (prev_h[i] == 2'b10 && h[i] == 2'b00) bad = 1'b1;
        if (prev_h[i] == 2'b00 && h[i] == 2'b01) bad = 1'b1;
      end
      checks++;
      if (nz > 1 || bad) begin
        errors++;
        $display("FAIL invariant cycle %0d: heads %b%b%b%b nonred %0d expected at most 1 legal",
                 cyc, h[3], h[2], h[1], h[0], nz);
      end
      for (int i = 0; i < 4; i++) prev_h[i] = h[i];
    end
  end

  initial begin
    ifc.req = 4'b0000; ifc.emerg_valid = 1'b0; ifc.emerg_dir = 2'd0;

    // No demand.
    segs.push_back(S(1, 50, 4'b0000, 0, 0, 8'h00, 3'd0, 2'd0));
    // Single request rests in green.
    segs.push_back(S(1,  2, 4'b0001, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0, 20, 4'b0001, 0, 0, 8'h02, 3'd1, 2'd0));
    // r1/r3 alternation with max-out.
    segs.push_back(S(1,  2, 4'b0101, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  8, 4'b0101, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  2, 4'b0101, 0, 0, 8'h01, 3'd2, 2'd0));
    segs.push_back(S(0,  2, 4'b0101, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  8, 4'b0101, 0, 0, 8'h20, 3'd1, 2'd2));
    segs.push_back(S(0,  2, 4'b0101, 0, 0, 8'h10, 3'd2, 2'd2));
    segs.push_back(S(0,  2, 4'b0101, 0, 0, 8'h00, 3'd0, 2'd2));
    segs.push_back(S(0,  8, 4'b0101, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  2, 4'b0101, 0, 0, 8'h01, 3'd2, 2'd0));
    // Gap-out at exactly MIN_GREEN.
    segs.push_back(S(1,  2, 4'b0011, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  1, 4'b0011, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  2, 4'b0010, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  2, 4'b0010, 0, 0, 8'h01, 3'd2, 2'd0));
    segs.push_back(S(0,  2, 4'b0010, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  6, 4'b0010, 0, 0, 8'h08, 3'd1, 2'd1));
    // Preemption to approach 3, then release back to r1.
    segs.push_back(S(1,  2, 4'b0001, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  1, 4'b0001, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  1, 4'b0001, 1, 2, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  2, 4'b0001, 1, 2, 8'h01, 3'd2, 2'd0));
    segs.push_back(S(0,  2, 4'b0001, 1, 2, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  6, 4'b0001, 1, 2, 8'h20, 3'd3, 2'd2));
    segs.push_back(S(0,  1, 4'b0001, 0, 0, 8'h20, 3'd3, 2'd2));
    segs.push_back(S(0,  2, 4'b0001, 0, 0, 8'h10, 3'd2, 2'd2));
    segs.push_back(S(0,  2, 4'b0001, 0, 0, 8'h00, 3'd0, 2'd2));
    segs.push_back(S(0,  6, 4'b0001, 0, 0, 8'h02, 3'd1, 2'd0));
    // Same-direction preemption keeps green; a direction change goes via yellow.
    segs.push_back(S(1,  2, 4'b0001, 0, 0, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  1, 4'b0001, 0, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  1, 4'b0001, 1, 0, 8'h02, 3'd1, 2'd0));
    segs.push_back(S(0,  5, 4'b0001, 1, 0, 8'h02, 3'd3, 2'd0));
    segs.push_back(S(0,  1, 4'b0001, 1, 1, 8'h02, 3'd3, 2'd0));
    segs.push_back(S(0,  2, 4'b0001, 1, 1, 8'h01, 3'd2, 2'd0));
    segs.push_back(S(0,  2, 4'b0001, 1, 1, 8'h00, 3'd0, 2'd0));
    segs.push_back(S(0,  3, 4'b0001, 1, 1, 8'h08, 3'd3, 2'd1));

    foreach (segs[i]) begin
      if (segs[i].rst_first) do_reset();
      run_seg(segs[i]);
    end

    // Reset asserted mid-green clears outputs without waiting for a clock edge.
    do_reset();
    run_seg(S(0, 2, 4'b0100, 0, 0, 8'h00, 3'd0, 2'd0));
    run_seg(S(0, 3, 4'b0100, 0, 0, 8'h20, 3'd1, 2'd2));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_heads", {ifc.r4, ifc.r3, ifc.r2, ifc.r1}, 8'h00);
    chk("async_rst_phase", 8'(ifc.phase), 8'd0);
    chk("async_rst_active_dir", 8'(ifc.active_dir), 8'd0);
    ifc.req = 4'b0001;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    run_seg(S(0, 2, 4'b0001, 0, 0, 8'h00, 3'd0, 2'd0));
    run_seg(S(0, 10, 4'b0001, 0, 0, 8'h02, 3'd1, 2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_demand_scheduler.md
# traffic_demand_scheduler

Demand-actuated phase scheduler for the 4-way intersection. It replaces fixed-time rotation with per-approach vehicle requests and round-robin fairness. It applies min/max green, gap-out and emergency preemption. Each signal head is driven with a 2-bit aspect, with mandatory yellow and all-red clearance between conflicting greens.

## Interface
Parameters:
- MIN_GREEN, 3, minimum green cycles once granted.
- MAX_GREEN, 8, green cycles after which a competing request forces max-out.
- YELLOW_TIME, 2, yellow cycles.
- ALL_RED_TIME, 2, minimum all-red clearance cycles.
- TIMER_W, 8, phase timer width.
- Legal ranges: 1 ≤ MIN_GREEN ≤ MAX_GREEN < 2^TIMER_W. YELLOW_TIME ≥ 1. ALL_RED_TIME ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  vehicle demand, level; bit i = approach i+1. Synchronous to clk; synchronizers are external.
- emerg_valid  in  1  emergency preemption request, level.
- emerg_dir  in  2  approach to preempt to (0..3).
- r1, r2, r3, r4  out  2 each  aspect: 00 RED, 01 YELLOW, 10 GREEN; 11 is never driven.
- active_dir  out  2  approach owning the current/last green.
- phase  out  3  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 EMERG.

## Operation
- Reset values: phase ALL_RED, timer 0, active_dir 0, round-robin pointer ptr 0, all r* = 00.
- Timer resets to 0 on every state entry. A state with duration T lasts T cycles and exits at the edge ending the cycle where timer == T-1.
- ALL_RED: all heads 00. After ALL_RED_TIME cycles, decide on each cycle:
  - If emerg_valid: enter EMERG with active_dir ← emerg_dir.
  - Else if req ≠ 0: pick the first set bit scanning ptr, ptr+1, … mod 4. Set active_dir ← pick, ptr ← pick+1 mod 4, enter GREEN.
  - Else dwell in ALL_RED. The timer saturates at ALL_RED_TIME-1 and the decision re-runs every cycle.
- GREEN: head[active_dir] = 10, others 00. Timer saturates at MAX_GREEN-1. Let other = req with bit active_dir masked.
  - emerg_valid and emerg_dir ≠ active_dir: go to YELLOW next edge, overriding MIN_GREEN.
  - emerg_valid and emerg_dir == active_dir: go to EMERG, no yellow, head stays 10.
  - Gap-out: timer ≥ MIN_GREEN-1, req[active_dir]==0 and other ≠ 0 → YELLOW.
  - Max-out: timer == MAX_GREEN-1 and other ≠ 0 → YELLOW.
  - other == 0: rest in green indefinitely.
- YELLOW: head[active_dir] = 01, others 00. Lasts YELLOW_TIME cycles, then ALL_RED. Preemption is not evaluated during YELLOW.
- EMERG: head[active_dir] = 10. Hold while emerg_valid and emerg_dir == active_dir.
  - If emerg_valid drops, or emerg_dir changes, go to YELLOW.
  - ptr is unchanged by emergency service.
- Invariant: at most one head non-red in any cycle. A head never goes 10→00 or 00→01 directly.
- Simultaneous requests resolve strictly by ptr order. Emergency outranks all vehicle requests.

## Timing
- All state, timer, ptr and output registers update on posedge clk. Outputs are registered, decoded from state, so there is no combinational input-to-output path.
- Inputs are sampled at posedge. A req change is acted on at the first edge after it is sampled, so a response appears one cycle later.
- rst assertion asynchronously forces reset values in the same instant, even mid-phase. Release starts a fresh ALL_RED of ALL_RED_TIME cycles.
- Worst-case wait for a continuously requesting approach:
  - 3 × (MAX_GREEN + YELLOW_TIME + ALL_RED_TIME) cycles, excluding emergency service.

## Test plan
Defaults: MIN=3, MAX=8, YELLOW=2, ALL_RED=2. Cycle 0 is the first cycle after rst release.
- No demand (req=0000, emerg_valid=0): all r* = 00 and phase=0 for 50 cycles; active_dir stays 0.
- req=0001 held: phase 0 in cycles 0–1, r1=10 from cycle 2 onward indefinitely; ptr becomes 1.
- req=0101 held: r1=10 for 8 cycles (2–9), 01 for 2 cycles, all-red 2, then r3=10 for 8. Alternation r1/r3 repeats; r2 and r4 stay 00.
- Gap-out: req[0] high only during cycles 0–2, req[1] held high. r1=10 in cycles 2–4 (exactly MIN), r1=01 in cycles 5–6, all-red 7–8, r2=10 from cycle 9.
- Preemption: req=0001, emerg_valid=1 with emerg_dir=2 sampled at cycle 3.
  - r1=01 in cycles 4–5, all-red 6–7, r3=10 from cycle 8 while valid.
  - Drop valid: r3 yellow 2 cycles, all-red 2, then r1=10 again.
- Reset mid-operation: assert rst during green at cycle 5. All r*=00, phase=0 and active_dir=0 are seen immediately. After release, behavior matches the second scenario from cycle 0.
- Every scenario checks continuously that no cycle has more than one non-00 head and no 11 aspect appears.
